// File: rtl/add_test_sequencer_pkg.sv
// Shared constants for the adder test sequencer: CSR map, CTRL/ERR bit positions,
// FSM states and the datapath latency other blocks also reference.
package add_test_pkg;

  localparam int LATENCY_DEFAULT = 5;

  localparam logic [2:0] CSR_ID     = 3'd0;
  localparam logic [2:0] CSR_CTRL   = 3'd1;
  localparam logic [2:0] CSR_START  = 3'd2;
  localparam logic [2:0] CSR_COUNT  = 3'd3;
  localparam logic [2:0] CSR_CYCLES = 3'd4;
  localparam logic [2:0] CSR_ERR    = 3'd5;

  // CTRL write pulses
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  // CTRL read status
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_LOCK = 2;
  // ERR sticky flags
  localparam int ERR_LOCK_LOST = 0;
  localparam int ERR_START_REJ = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/add_test_sequencer_if.sv
// Avalon-MM CSR bus between a host master and the sequencer slave.
interface add_test_sequencer_if;
  logic        read;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output read, write, address, writedata, input readdata);
  modport slave  (input read, write, address, writedata, output readdata);
endinterface

// File: rtl/add_test_sequencer_wr_addr_pipe.sv
// Fixed-depth delay line carrying {enable, address}; cleared synchronously on resetn.
module wr_addr_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             en_i,
  input  logic [WIDTH-1:0] addr_i,
  output logic             en_o,
  output logic [WIDTH-1:0] addr_o
);

  logic [WIDTH:0] pipe_q [DEPTH];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {en_i, addr_i};
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {en_o, addr_o} = pipe_q[DEPTH-1];

endmodule

// File: rtl/add_test_sequencer.sv
// Streams a programmed block of operand read addresses, then replays them as result
// writes LATENCY cycles later so each sum lands at its operands' address.
module add_test_sequencer
  import add_test_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = LATENCY_DEFAULT,
  parameter int ID         = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  add_test_sequencer_if.slave   csr,
  input  logic                  pll_lock,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] w_addr
);

  localparam logic [ADDR_WIDTH:0] IDX_ONE    = 1;
  localparam logic [3:0]          DRAIN_LAST = 4'(LATENCY - 1);

  seq_state_e            state_q;
  logic [ADDR_WIDTH-1:0] start_addr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   idx_q;
  logic [3:0]            drain_q;
  logic [31:0]           cycles_q;
  logic [1:0]            err_q;
  logic                  done_q;
  logic                  lock_q;
  logic                  r_en_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [31:0]           readdata_q;
  logic [31:0]           rd_mux;

  logic busy, wr_ctrl, start_req, abort_req;

  assign busy      = (state_q != IDLE);
  assign wr_ctrl   = csr.write && (csr.address == CSR_CTRL);
  // abort takes precedence over a start in the same write
  assign abort_req = wr_ctrl && csr.writedata[CTRL_ABORT];
  assign start_req = wr_ctrl && csr.writedata[CTRL_START] && !csr.writedata[CTRL_ABORT];

  always_comb begin
    rd_mux = '0;
    case (csr.address)
      CSR_ID:     rd_mux = 32'(ID);
      CSR_CTRL: begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_DONE] = done_q;
        rd_mux[STAT_LOCK] = pll_lock;
      end
      CSR_START:  rd_mux[ADDR_WIDTH-1:0] = start_addr_q;
      CSR_COUNT:  rd_mux[ADDR_WIDTH:0]   = count_q;
      CSR_CYCLES: rd_mux = cycles_q;
      CSR_ERR:    rd_mux[1:0] = err_q;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      start_addr_q <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      drain_q      <= '0;
      cycles_q     <= '0;
      err_q        <= '0;
      done_q       <= 1'b0;
      lock_q       <= 1'b0;
      r_en_q       <= 1'b0;
      r_addr_q     <= '0;
      readdata_q   <= '0;
    end else begin
      lock_q     <= pll_lock;
      readdata_q <= csr.read ? rd_mux : '0;
      if (busy) cycles_q <= cycles_q + 32'd1;

      if (csr.write && !busy && csr.address == CSR_START)
        start_addr_q <= csr.writedata[ADDR_WIDTH-1:0];
      if (csr.write && !busy && csr.address == CSR_COUNT)
        count_q <= csr.writedata[ADDR_WIDTH:0];
      // write-one-to-clear; a flag raised this same cycle below still wins
      if (csr.write && csr.address == CSR_ERR)
        err_q <= err_q & ~csr.writedata[1:0];

      case (state_q)
        IDLE: begin
          if (start_req) begin
            if (!pll_lock) begin
              err_q[ERR_START_REJ] <= 1'b1;
            end else if (count_q == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q  <= ISSUE;
              done_q   <= 1'b0;
              cycles_q <= '0;
              r_en_q   <= 1'b1;
              r_addr_q <= start_addr_q;
              idx_q    <= IDX_ONE;
            end
          end
        end
        ISSUE: begin
          if (abort_req || !pll_lock || idx_q == count_q) begin
            state_q <= DRAIN;
            r_en_q  <= 1'b0;
            drain_q <= '0;
            if (!pll_lock) err_q[ERR_LOCK_LOST] <= 1'b1;
          end else begin
            r_addr_q <= start_addr_q + idx_q[ADDR_WIDTH-1:0];
            idx_q    <= idx_q + IDX_ONE;
          end
        end
        DRAIN: begin
          if (lock_q && !pll_lock) err_q[ERR_LOCK_LOST] <= 1'b1;
          if (drain_q == DRAIN_LAST) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign csr.readdata = readdata_q;
  assign r_en         = r_en_q;
  assign r_addr       = r_addr_q;

  wr_addr_pipe #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (LATENCY)
  ) u_wr_addr_pipe (
    .clock  (clock),
    .resetn (resetn),
    .en_i   (r_en_q),
    .addr_i (r_addr_q),
    .en_o   (we),
    .addr_o (w_addr)
  );

endmodule

// File: tb/tb_add_test_sequencer.sv
// Self-checking bench for add_test_sequencer: table of full runs plus hand-written
// reject, no-op, abort, lock-loss and mid-drain reset sequences.
module tb_add_test_sequencer;
  import add_test_pkg::*;

  localparam int LAT = 5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_lock = 1'b1;
  logic       r_en, we;
  logic [7:0] r_addr, w_addr;

  add_test_sequencer_if csr_if ();

  add_test_sequencer #(.ADDR_WIDTH(8), .LATENCY(LAT), .ID(8)) dut (
    .clock    (clk),
    .resetn   (resetn),
    .csr      (csr_if.slave),
    .pll_lock (pll_lock),
    .r_en     (r_en),
    .r_addr   (r_addr),
    .we       (we),
    .w_addr   (w_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard: expected read/write addresses queued when a run is launched
  logic [7:0] r_exp[$];
  logic [7:0] w_exp[$];
  int         w_due[$];
  int         r_seen = 0, w_seen = 0, last_r = 0;

  always @(negedge clk) begin
    if (r_en) begin
      if (r_seen > 0) check("r_contig", cyc, last_r + 1);
      r_seen++;
      last_r = cyc;
      if (r_exp.size() == 0) check("r_extra", 1, 0);
      else check("r_addr", int'(r_addr), int'(r_exp.pop_front()));
      w_due.push_back(cyc + LAT);
    end
    if (we) begin
      w_seen++;
      if (w_exp.size() == 0) check("w_extra", 1, 0);
      else check("w_addr", int'(w_addr), int'(w_exp.pop_front()));
      if (w_due.size() == 0) check("w_nodue", 1, 0);
      else check("w_latency", cyc, w_due.pop_front());
    end
  end

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_if.write = 1'b1; csr_if.address = a; csr_if.writedata = d;
    @(negedge clk);
    csr_if.write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_if.read = 1'b1; csr_if.address = a;
    @(negedge clk);
    csr_if.read = 1'b0;
    d = csr_if.readdata;
  endtask

  task automatic sb_clear();
    r_exp.delete(); w_exp.delete(); w_due.delete();
    r_seen = 0; w_seen = 0;
  endtask

  task automatic sb_push(input logic [7:0] sa, input int n_r, input int n_w);
    for (int i = 0; i < n_r; i++) r_exp.push_back(sa + 8'(i));
    for (int i = 0; i < n_w; i++) w_exp.push_back(sa + 8'(i));
  endtask

  typedef struct {
    logic [7:0] sa;
    int         cnt;
    int         exp_cycles;
    int         exp_ctrl;
  } run_vec_t;

  run_vec_t vecs[4];
  logic [31:0] d;

  initial begin
    vecs[0] = '{sa: 8'h10, cnt: 4,   exp_cycles: 9,   exp_ctrl: 6};
    vecs[1] = '{sa: 8'hFE, cnt: 4,   exp_cycles: 9,   exp_ctrl: 6};
    vecs[2] = '{sa: 8'h00, cnt: 256, exp_cycles: 261, exp_ctrl: 6};
    vecs[3] = '{sa: 8'h80, cnt: 1,   exp_cycles: 6,   exp_ctrl: 6};

    csr_if.read = 1'b0; csr_if.write = 1'b0;
    csr_if.address = '0; csr_if.writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_r_en", int'(r_en), 0);
    check("rst_we", int'(we), 0);
    check("rst_readdata", int'(csr_if.readdata), 0);
    resetn = 1'b1;

    csr_rd(CSR_ID, d);     check("id", d, 8);
    csr_rd(CSR_CTRL, d);   check("rst_ctrl", d, 32'h4);
    csr_rd(CSR_COUNT, d);  check("rst_count", d, 0);
    csr_rd(CSR_CYCLES, d); check("rst_cycles", d, 0);
    csr_rd(CSR_ERR, d);    check("rst_err", d, 0);
    csr_rd(3'd7, d);       check("unmapped", d, 0);

    // start without PLL lock is rejected
    sb_clear();
    csr_wr(CSR_START, 32'h10);
    csr_wr(CSR_COUNT, 32'd4);
    pll_lock = 1'b0;
    csr_wr(CSR_CTRL, 32'h1);
    repeat (LAT + 4) @(negedge clk);
    csr_rd(CSR_CTRL, d);   check("rej_ctrl", d, 0);
    csr_rd(CSR_ERR, d);    check("rej_err", d, 2);
    check("rej_no_reads", r_seen, 0);
    pll_lock = 1'b1;
    csr_wr(CSR_ERR, 32'h2);
    csr_rd(CSR_ERR, d);    check("err_w1c", d, 0);

    // COUNT=0 is a no-op that still reports done
    csr_wr(CSR_COUNT, 32'd0);
    csr_wr(CSR_CTRL, 32'h1);
    repeat (LAT + 4) @(negedge clk);
    csr_rd(CSR_CTRL, d);   check("noop_ctrl", d, 6);
    check("noop_no_reads", r_seen, 0);

    for (int v = 0; v < 4; v++) begin
      sb_clear();
      sb_push(vecs[v].sa, vecs[v].cnt, vecs[v].cnt);
      csr_wr(CSR_START, 32'(vecs[v].sa));
      csr_wr(CSR_COUNT, 32'(vecs[v].cnt));
      csr_wr(CSR_CTRL, 32'h1);
      csr_rd(CSR_CTRL, d);   check("run_busy", int'(d[0]), 1);
      csr_wr(CSR_START, 32'h55);
      repeat (vecs[v].cnt + LAT + 8) @(negedge clk);
      check("run_reads", r_seen, vecs[v].cnt);
      check("run_writes", w_seen, vecs[v].cnt);
      check("run_w_left", w_exp.size(), 0);
      csr_rd(CSR_CTRL, d);   check("run_ctrl", d, vecs[v].exp_ctrl);
      csr_rd(CSR_CYCLES, d); check("run_cycles", d, vecs[v].exp_cycles);
      csr_rd(CSR_START, d);  check("busy_wr_ignored", d, int'(vecs[v].sa));
    end

    // abort after exactly three issues
    sb_clear();
    sb_push(8'h40, 3, 3);
    csr_wr(CSR_START, 32'h40);
    csr_wr(CSR_COUNT, 32'd10);
    csr_wr(CSR_CTRL, 32'h1);
    @(negedge clk);
    csr_wr(CSR_CTRL, 32'h3);
    repeat (LAT + 8) @(negedge clk);
    check("abort_reads", r_seen, 3);
    check("abort_writes", w_seen, 3);
    csr_rd(CSR_CTRL, d);   check("abort_ctrl", d, 6);

    // PLL lock lost after two issues behaves like abort and flags lock_lost
    sb_clear();
    sb_push(8'h20, 2, 2);
    csr_wr(CSR_START, 32'h20);
    csr_wr(CSR_CTRL, 32'h1);
    @(negedge clk);
    pll_lock = 1'b0;
    repeat (LAT + 8) @(negedge clk);
    pll_lock = 1'b1;
    check("lock_reads", r_seen, 2);
    check("lock_writes", w_seen, 2);
    csr_rd(CSR_ERR, d);    check("lock_err", d, 1);
    csr_rd(CSR_CTRL, d);   check("lock_ctrl", d, 6);
    csr_wr(CSR_ERR, 32'h1);

    // reset during DRAIN: two writes land, the rest never appear
    sb_clear();
    sb_push(8'h30, 4, 2);
    csr_wr(CSR_START, 32'h30);
    csr_wr(CSR_COUNT, 32'd4);
    csr_wr(CSR_CTRL, 32'h1);
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_drain_we", int'(we), 0);
    check("rst_drain_r_en", int'(r_en), 0);
    resetn = 1'b1;
    w_due.delete();
    repeat (LAT + 6) @(negedge clk);
    check("rst_drain_reads", r_seen, 4);
    check("rst_drain_writes", w_seen, 2);
    csr_rd(CSR_CTRL, d);   check("rst_drain_ctrl", d, 32'h4);
    csr_rd(CSR_COUNT, d);  check("rst_drain_count", d, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
